// File: rtl/chdeint_pkg.sv
// ---------------------------------------------------------------------------
// chdeint_pkg
// Shared constants, FSM state type and the n_slots -> matrix geometry lookup
// for the NB-IoT uplink channel deinterleaver.
// ---------------------------------------------------------------------------
package chdeint_pkg;

    localparam int NBITS  = 2880;   // R*C for every legal slot count
    localparam int NS_W   = 5;      // n_slots width
    localparam int ADDR_W = 12;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 7;
    localparam int CNT_W  = 12;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             legal;
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
    } geom_t;

    // Matrix geometry for a slot count; legal=0 for anything but 2/4/8/16.
    function automatic geom_t slot_geom(input logic [NS_W-1:0] n_slots);
        geom_t g;
        g.legal = 1'b1;
        g.r     = '0;
        g.c     = '0;
        case (n_slots)
            5'd2:    begin g.r = 8'd240; g.c = 7'd12; end
            5'd4:    begin g.r = 8'd120; g.c = 7'd24; end
            5'd8:    begin g.r = 8'd60;  g.c = 7'd48; end
            5'd16:   begin g.r = 8'd30;  g.c = 7'd96; end
            default: g.legal = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/channel_deinterleaver_if.sv
// ---------------------------------------------------------------------------
// channel_deinterleaver_if
// Bit-serial input/output bundle of the deinterleaver.
//   master : drives n_slots, in_en, d; observes y, out_en, busy, done, cfg_err
//   slave  : the deinterleaver itself
// ---------------------------------------------------------------------------
interface channel_deinterleaver_if;
    import chdeint_pkg::*;

    logic [NS_W-1:0] n_slots;
    logic            in_en;
    logic            d;
    logic            y;
    logic            out_en;
    logic            busy;
    logic            done;
    logic            cfg_err;

    modport master (output n_slots, in_en, d,
                    input  y, out_en, busy, done, cfg_err);
    modport slave  (input  n_slots, in_en, d,
                    output y, out_en, busy, done, cfg_err);
endinterface

// File: rtl/deint_bitmem.sv
// ---------------------------------------------------------------------------
// deint_bitmem
// DEPTH x 1 single-port RAM: synchronous write, registered read.
//   clk, reset : clock; reset clears only the read register, not the array
//   we, wdata  : write strobe / data
//   re, rdata  : read strobe / registered data (holds when re=0)
//   addr       : shared address
// ---------------------------------------------------------------------------
module deint_bitmem
    import chdeint_pkg::*;
#(
    parameter int DEPTH = NBITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wdata,
    output logic              rdata
);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= 1'b0;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/channel_deinterleaver.sv
// ---------------------------------------------------------------------------
// channel_deinterleaver
// Receive-side inverse of the NB-IoT uplink channel interleaver. Takes a
// 2880-bit frame arriving column-major over an R x C matrix, stores it at
// its row-major address, then streams out the first K+4 bits in order and
// drops the zero padding.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : n_slots/in_en/d in; y/out_en/busy/done/cfg_err out
// ---------------------------------------------------------------------------
module channel_deinterleaver
    import chdeint_pkg::*;
#(
    parameter int K = 2560
) (
    input  logic                    clk,
    input  logic                    reset,
    channel_deinterleaver_if.slave  bus
);

    localparam int OUT_LAST = K + 3;

    state_t            state;
    logic [ROW_W-1:0]  r_q, row;
    logic [COL_W-1:0]  c_q, col;
    logic [ADDR_W-1:0] wr_addr, rd_addr, mem_addr;
    logic [CNT_W-1:0]  cnt;
    logic              out_en_q, busy_q, done_q, cfg_err_q;
    logic              mem_rdata;

    geom_t geom;
    logic  start, accept, mem_we, mem_re;

    assign geom   = slot_geom(bus.n_slots);
    assign start  = (state == IDLE) && bus.in_en && geom.legal;
    assign accept = (state == FILL) && bus.in_en;
    assign mem_we = !reset && (start || accept);
    assign mem_re = !reset && (state == DRAIN);

    // The first bit always lands at address 0; afterwards FILL owns the
    // port for writes and DRAIN for reads.
    always_comb begin
        mem_addr = rd_addr;
        if (start)
            mem_addr = '0;
        else if (state == FILL)
            mem_addr = wr_addr;
    end

    deint_bitmem #(.DEPTH(NBITS)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (bus.d),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r_q       <= '0;
            c_q       <= '0;
            row       <= '0;
            col       <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            cnt       <= '0;
            out_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            out_en_q  <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_en) begin
                        if (geom.legal) begin
                            r_q     <= geom.r;
                            c_q     <= geom.c;
                            row     <= ROW_W'(1);
                            col     <= '0;
                            wr_addr <= ADDR_W'(geom.c);
                            cnt     <= CNT_W'(1);
                            busy_q  <= 1'b1;
                            state   <= FILL;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.in_en) begin
                        cnt <= cnt + CNT_W'(1);
                        // Address walks down a column in steps of C, then
                        // restarts at the top of the next column.
                        if (row == r_q - ROW_W'(1)) begin
                            row     <= '0;
                            col     <= col + COL_W'(1);
                            wr_addr <= ADDR_W'(col) + ADDR_W'(1);
                        end else begin
                            row     <= row + ROW_W'(1);
                            wr_addr <= wr_addr + ADDR_W'(c_q);
                        end
                        if (cnt == CNT_W'(NBITS - 1)) begin
                            state   <= DRAIN;
                            rd_addr <= '0;
                        end
                    end
                end
                DRAIN: begin
                    out_en_q <= 1'b1;
                    rd_addr  <= rd_addr + ADDR_W'(1);
                    if (rd_addr == ADDR_W'(OUT_LAST))
                        state <= DONE;
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y       = mem_rdata;
    assign bus.out_en  = out_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_channel_deinterleaver.sv
// ---------------------------------------------------------------------------
// tb_channel_deinterleaver
// Directed bench: builds frames, interleaves them with a reference model,
// feeds them serially and compares the deinterleaved stream, latency,
// done/busy/cfg_err behaviour and reset aborts.
// ---------------------------------------------------------------------------
module tb_channel_deinterleaver;
    import chdeint_pkg::*;

    localparam int K  = 2560;
    localparam int K4 = K + 4;

    logic clk = 1'b0;
    logic reset;

    channel_deinterleaver_if bus();

    channel_deinterleaver #(.K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output monitor: samples shortly after every rising edge.
    int   cyc = 0;
    logic got_q[$];
    int   oe_cyc_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   cfg_cnt  = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (bus.out_en === 1'b1) begin
            got_q.push_back(bus.y);
            oe_cyc_q.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus.cfg_err === 1'b1)
            cfg_cnt = cfg_cnt + 1;
    end

    logic a_exp [NBITS];
    logic s     [NBITS];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    int   acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: a[n] = (n mod 3 == 0); mode 1: random payload. Padding is zero.
    // s[] is the interleaver output: column-major read of the row-major matrix.
    task automatic build_frame(input int ns, input int mode);
        int r, c;
        r = 480 / ns;
        c = 6 * ns;
        for (int n = 0; n < NBITS; n++) begin
            if (n >= K4)       a_exp[n] = 1'b0;
            else if (mode == 0) a_exp[n] = (n % 3 == 0);
            else               a_exp[n] = 1'($urandom_range(0, 1));
        end
        for (int m = 0; m < NBITS; m++)
            s[m] = a_exp[(m % r) * c + m / r];
    endtask

    // Drive nbits of s[] at negedges; alt_ns (if nonzero) replaces n_slots
    // after the first bit; noise keeps in_en=1,d=1 after the last bit.
    task automatic feed(input int ns, input int nbits, input int gap_pct,
                        input int alt_ns, input bit noise);
        for (int m = 0; m < nbits; m++) begin
            @(negedge clk);
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                bus.in_en = 1'b0;
                bus.d     = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.in_en   = 1'b1;
            bus.d       = s[m];
            bus.n_slots = (m == 0 || alt_ns == 0) ? 5'(ns) : 5'(alt_ns);
        end
        @(negedge clk);
        acc_cyc   = cyc;
        bus.in_en = noise;
        bus.d     = 1'b1;
    endtask

    task automatic wait_done(output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 4000) begin
            if (bus.done === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk);
                t = t + 1;
            end
        end
        bus.in_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int base, input int dbase);
        bit ok;
        int n, errs;
        wait_done(ok);
        check({tag, "_done_seen"}, 32'(ok), 1);
        n = got_q.size() - base;
        check({tag, "_out_count"}, n, K4);
        errs = 0;
        for (int i = 0; i < n && i < K4; i++)
            if (got_q[base + i] !== a_exp[i]) errs++;
        check({tag, "_data_errs"}, errs, 0);
        if (n > 0) begin
            check({tag, "_first_latency"}, oe_cyc_q[base] - acc_cyc, 1);
            check({tag, "_contiguous"}, oe_cyc_q[base + n - 1] - oe_cyc_q[base], K4 - 1);
            check({tag, "_done_gap"}, done_cyc - oe_cyc_q[base + n - 1], 1);
        end
        check({tag, "_done_pulses"}, done_cnt - dbase, 1);
        check({tag, "_busy_after"}, 32'(bus.busy), 0);
    endtask

    task automatic full(input string tag, input int ns, input int mode,
                        input int gap_pct, input int alt_ns, input bit noise);
        int base, dbase;
        base  = got_q.size();
        dbase = done_cnt;
        build_frame(ns, mode);
        feed(ns, NBITS, gap_pct, alt_ns, noise);
        check_frame(tag, base, dbase);
    endtask

    initial begin
        int base, dbase, cb, t;
        bus.in_en   = 1'b0;
        bus.d       = 1'b0;
        bus.n_slots = 5'd2;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_y",       32'(bus.y),       0);
        check("rst_out_en",  32'(bus.out_en),  0);
        check("rst_busy",    32'(bus.busy),    0);
        check("rst_done",    32'(bus.done),    0);
        check("rst_cfg_err", 32'(bus.cfg_err), 0);
        reset = 1'b0;
        @(negedge clk);

        // Patterned frame, no gaps
        full("A", 2, 0, 0, 0, 0);
        // Random payload with ~30% idle cycles
        full("B", 16, 1, 30, 0, 0);
        // Back-to-back frames; n_slots changed mid-frame must be ignored
        full("C", 4, 1, 0, 16, 0);
        full("D", 8, 1, 0, 2, 0);

        // Illegal slot count on a frame start
        base = got_q.size();
        cb   = cfg_cnt;
        @(negedge clk);
        bus.n_slots = 5'd3;
        bus.in_en   = 1'b1;
        bus.d       = 1'b1;
        @(negedge clk);
        bus.in_en = 1'b0;
        check("cfg_err_pulse", 32'(bus.cfg_err), 1);
        check("cfg_busy",      32'(bus.busy),    0);
        @(negedge clk);
        check("cfg_err_width", 32'(bus.cfg_err), 0);
        check("cfg_err_count", cfg_cnt - cb, 1);
        repeat (10) @(negedge clk);
        check("cfg_no_out",    got_q.size() - base, 0);
        check("cfg_busy_late", 32'(bus.busy), 0);
        full("E", 8, 1, 10, 0, 0);

        // Reset in the middle of FILL
        build_frame(2, 1);
        base  = got_q.size();
        dbase = done_cnt;
        feed(2, 1500, 0, 0, 0);
        check("rstf_busy_mid", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstf_out_en", 32'(bus.out_en), 0);
        check("rstf_busy",   32'(bus.busy),   0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rstf_no_done", done_cnt - dbase, 0);
        check("rstf_no_out",  got_q.size() - base, 0);
        full("F", 4, 1, 0, 0, 0);

        // Reset in the middle of DRAIN
        build_frame(16, 1);
        base  = got_q.size();
        dbase = done_cnt;
        feed(16, NBITS, 0, 0, 0);
        t = 0;
        while (got_q.size() - base < 100 && t < 3000) begin
            @(negedge clk);
            t = t + 1;
        end
        check("rstd_reached", got_q.size() - base, 100);
        reset = 1'b1;
        @(negedge clk);
        check("rstd_out_en", 32'(bus.out_en), 0);
        check("rstd_busy",   32'(bus.busy),   0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("rstd_no_done", done_cnt - dbase, 0);
        check("rstd_out_cnt", got_q.size() - base, 100);
        full("G", 2, 1, 0, 0, 0);

        // in_en held high with d=1 through DRAIN/DONE
        full("H", 4, 1, 0, 0, 1);

        repeat (5) @(negedge clk);
        check("total_out", got_q.size(), 8 * K4 + 100);
        check("final_busy", 32'(bus.busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
